// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, byte type, SubBytes FSM states and byte access helpers
package aes_pkg;
   localparam int AES_STATE_W = 128;
   localparam int AES_BYTE_W  = 8;

   typedef logic [AES_BYTE_W-1:0] aes_byte_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } aes_fsm_t;

   // Byte 0 sits in the most significant byte of the state.
   function automatic aes_byte_t get_byte(input logic [AES_STATE_W-1:0] s, input int i);
      return s[AES_STATE_W-1-AES_BYTE_W*i -: AES_BYTE_W];
   endfunction

   function automatic logic [AES_STATE_W-1:0] set_byte(input logic [AES_STATE_W-1:0] s,
                                                      input int i, input aes_byte_t b);
      logic [AES_STATE_W-1:0] r;
      r = s;
      r[AES_STATE_W-1-AES_BYTE_W*i -: AES_BYTE_W] = b;
      return r;
   endfunction
endpackage

// File: rtl/InverseS_Box.sv
// rtl/InverseS_Box.sv - inverse AES S-box, purely combinational 8-bit lookup
// Only compiled when SUB_BYTES_INV_EN is defined.
`ifdef SUB_BYTES_INV_EN
module InverseS_Box (
   input  logic [7:0] in,
   output logic [7:0] out
);
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   assign out = INV_SBOX[{~in, 3'b000} +: 8];
endmodule
`endif

// File: rtl/S_Box.sv
// rtl/S_Box.sv - forward AES S-box, purely combinational 8-bit lookup
// Table entry 0 occupies the most significant byte.
module S_Box (
   input  logic [7:0] in,
   output logic [7:0] out
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out = SBOX[{~in, 3'b000} +: 8];
endmodule

// File: rtl/aes_sub_bytes_iter.sv
// rtl/aes_sub_bytes_iter.sv - iterative AES SubBytes engine, BYTES_PER_CYCLE S-box lanes per step
// Define SUB_BYTES_INV_EN to add inv_mode and inverse S-box lanes for the decryption datapath.
module aes_sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_state,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_state,
`ifdef SUB_BYTES_INV_EN
   input  logic                   inv_mode,
`endif
   output logic                   busy
);
   localparam int NUM_STEPS = (AES_STATE_W / AES_BYTE_W) / BYTES_PER_CYCLE;
   localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
         BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_cfg
      $error("aes_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   aes_fsm_t                          state, state_next;
   logic [STEP_W-1:0]                 step;
   logic [AES_STATE_W-1:0]            work, work_next;
   logic [BYTES_PER_CYCLE-1:0][7:0]   lane_in;
   logic [BYTES_PER_CYCLE-1:0][7:0]   lane_out;
`ifdef SUB_BYTES_INV_EN
   logic                              mode;
`endif

   for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
      aes_byte_t fwd;
      assign lane_in[j] = get_byte(work, int'(step) * BYTES_PER_CYCLE + j);
      S_Box u_fwd (.in(lane_in[j]), .out(fwd));
`ifdef SUB_BYTES_INV_EN
      aes_byte_t inv;
      InverseS_Box u_inv (.in(lane_in[j]), .out(inv));
      assign lane_out[j] = mode ? inv : fwd;
`else
      assign lane_out[j] = fwd;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         step  <= '0;
         work  <= '0;
`ifdef SUB_BYTES_INV_EN
         mode  <= 1'b0;
`endif
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (in_valid) begin
               work <= in_state;
               step <= '0;
`ifdef SUB_BYTES_INV_EN
               mode <= inv_mode;
`endif
            end
            RUN: begin
               work <= work_next;
               step <= (step == LAST_STEP) ? '0 : step + STEP_W'(1);
            end
            default: ;
         endcase
      end
   end

   // out_state is masked outside DONE so a partially substituted state never appears.
   always_comb begin
      state_next = state;
      work_next  = work;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      out_state  = '0;
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         work_next = set_byte(work_next, int'(step) * BYTES_PER_CYCLE + j, lane_out[j]);
      end
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_next = RUN;
         end
         RUN: if (step == LAST_STEP) state_next = DONE;
         DONE: begin
            out_valid = 1'b1;
            out_state = work;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// tb/tb_aes_sub_bytes_iter.sv - self-checking bench for aes_sub_bytes_iter at 4, 1 and 16 bytes per cycle
// Reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_sub_bytes_iter;
   localparam int ND = 3;
   int bpc [ND] = '{4, 1, 16};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid  [ND];
   logic         in_ready  [ND];
   logic [127:0] in_state  [ND];
   logic         out_valid [ND];
   logic         out_ready [ND];
   logic [127:0] out_state [ND];
   logic         busy      [ND];
   logic         inv_mode  [ND];

   int checks = 0;
   int errors = 0;
   logic [7:0] rfwd [256];
   logic [7:0] rinv [256];

   always #5 clk = ~clk;

   aes_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_state(in_state[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_state(out_state[0]),
`ifdef SUB_BYTES_INV_EN
      .inv_mode(inv_mode[0]),
`endif
      .busy(busy[0]));

   aes_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_state(in_state[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_state(out_state[1]),
`ifdef SUB_BYTES_INV_EN
      .inv_mode(inv_mode[1]),
`endif
      .busy(busy[1]));

   aes_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_state(in_state[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_state(out_state[2]),
`ifdef SUB_BYTES_INV_EN
      .inv_mode(inv_mode[2]),
`endif
      .busy(busy[2]));

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
      logic [15:0] w;
      w = {v, v} << n;
      return w[15:8];
   endfunction

   function automatic logic [7:0] sbox_model(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
         if (a != 8'h00 && gf_mul(a, 8'(x)) == 8'h01) inv = 8'(x);
      end
      return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] ref_sub(input logic [127:0] s, input bit inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         r[127-8*i -: 8] = inv ? rinv[s[127-8*i -: 8]] : rfwd[s[127-8*i -: 8]];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_one(input int d, input logic [127:0] din, input logic [127:0] dexp,
                          input string name, input bit inv);
      int n;
      int lat;
      @(negedge clk);
      in_state[d]  = din;
      in_valid[d]  = 1'b1;
      out_ready[d] = 1'b1;
      inv_mode[d]  = inv;
      n = 0;
      while (!in_ready[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, " accept"}, 128'(in_ready[d]), 128'd1);
      @(negedge clk);
      in_valid[d] = 1'b0;
      inv_mode[d] = 1'b0;
      lat = 0;
      while (!out_valid[d] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, 128'(lat), 128'(16 / bpc[d]));
      check({name, " data"}, out_state[d], dexp);
      @(negedge clk);
      check({name, " in_ready after"}, 128'(in_ready[d]), 128'd1);
   endtask

   typedef struct {
      logic [127:0] din;
      logic [127:0] dexp;
   } vec_t;
   vec_t tbl [6];

   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

   initial begin
      logic [127:0] r;
      int g;
      for (int a = 0; a < 256; a++) begin
         rfwd[a] = sbox_model(8'(a));
         rinv[rfwd[a]] = 8'(a);
      end
      tbl[0] = '{128'h0, {16{8'h63}}};
      tbl[1] = '{{8'h53, 120'h0}, {8'hed, {15{8'h63}}}};
      tbl[2] = '{{8'h40, 120'h0}, {8'h09, {15{8'h63}}}};
      tbl[3] = '{{8'he2, 120'h0}, {8'h98, {15{8'h63}}}};
      tbl[4] = '{{8'h1b, 120'h0}, {8'haf, {15{8'h63}}}};
      tbl[5] = '{FIPS_IN, FIPS_OUT};

      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) begin
         in_valid[d] = 1'b0; in_state[d] = '0; out_ready[d] = 1'b1; inv_mode[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         check($sformatf("reset in_ready d%0d", d), 128'(in_ready[d]), 128'd1);
         check($sformatf("reset out_valid d%0d", d), 128'(out_valid[d]), 128'd0);
         check($sformatf("reset out_state d%0d", d), out_state[d], 128'd0);
         check($sformatf("reset busy d%0d", d), 128'(busy[d]), 128'd0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_one(0, tbl[i].din, tbl[i].dexp, $sformatf("vec%0d", i), 1'b0);
      run_one(1, FIPS_IN, FIPS_OUT, "fips b1", 1'b0);
      run_one(2, FIPS_IN, FIPS_OUT, "fips b16", 1'b0);

      for (int i = 0; i < 15; i++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         run_one(i % ND, r, ref_sub(r, 1'b0), $sformatf("rand%0d", i), 1'b0);
      end

      // Backpressure: hold DONE for 10 cycles.
      @(negedge clk);
      in_state[0] = FIPS_IN; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
      @(negedge clk);
      in_valid[0] = 1'b0;
      g = 0;
      while (!out_valid[0] && g < 100) begin @(negedge clk); g++; end
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp valid %0d", i), 128'(out_valid[0]), 128'd1);
         check($sformatf("bp data %0d", i), out_state[0], FIPS_OUT);
         check($sformatf("bp in_ready %0d", i), 128'(in_ready[0]), 128'd0);
         check($sformatf("bp busy %0d", i), 128'(busy[0]), 128'd1);
         @(negedge clk);
      end
      out_ready[0] = 1'b1;
      @(negedge clk);
      check("bp release out_valid", 128'(out_valid[0]), 128'd0);
      check("bp release in_ready", 128'(in_ready[0]), 128'd1);
      check("bp release busy", 128'(busy[0]), 128'd0);

      // Back-to-back with in_valid held high.
      in_state[0] = '0; in_valid[0] = 1'b1;
      @(negedge clk);
      in_state[0] = {16{8'hff}};
      g = 0;
      while (!out_valid[0] && g < 100) begin @(negedge clk); g++; end
      check("b2b first latency", 128'(g), 128'd4);
      check("b2b first data", out_state[0], {16{8'h63}});
      @(negedge clk);
      g = 1;
      check("b2b gap in_ready", 128'(in_ready[0]), 128'd1);
      check("b2b gap out_valid", 128'(out_valid[0]), 128'd0);
      @(negedge clk);
      g = 2;
      in_valid[0] = 1'b0;
      while (!out_valid[0] && g < 100) begin @(negedge clk); g++; end
      check("b2b period", 128'(g), 128'd6);
      check("b2b second data", out_state[0], {16{8'h16}});
      @(negedge clk);

      // Reset at step 2.
      in_state[0] = FIPS_IN; in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst mid out_valid", 128'(out_valid[0]), 128'd0);
      check("rst mid in_ready", 128'(in_ready[0]), 128'd1);
      check("rst mid out_state", out_state[0], 128'd0);
      check("rst mid busy", 128'(busy[0]), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      r = {$urandom, $urandom, $urandom, $urandom};
      run_one(0, r, ref_sub(r, 1'b0), "post reset", 1'b0);

`ifdef SUB_BYTES_INV_EN
      run_one(0, FIPS_OUT, FIPS_IN, "inv fips", 1'b1);
      run_one(0, {8'h09, {15{8'h63}}}, {8'h40, 120'h0}, "inv 09", 1'b1);
      run_one(0, {8'h98, {15{8'h63}}}, {8'he2, 120'h0}, "inv 98", 1'b1);
      run_one(0, {8'haf, {15{8'h63}}}, {8'h1b, 120'h0}, "inv af", 1'b1);
      for (int i = 0; i < 6; i++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         run_one(i % ND, r, ref_sub(r, 1'b1), $sformatf("inv rand%0d", i), 1'b1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
